// File: rtl/dsp_arb_pkg.sv
// dsp_arb_pkg: shared state encoding and operand widths for the DSP48A1 share arbiter.
package dsp_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam int A_W  = 18;
    localparam int B_W  = 18;
    localparam int C_W  = 48;
    localparam int OP_W = 8;
    localparam int P_W  = 48;
endpackage

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: LAT-deep {valid,id} shift register that follows each issued op through the slice.
module dsp_tag_pipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);
    logic [LAT-1:0] v;
    logic [LAT-1:0] id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v  <= '0;
            id <= '0;
        end else begin
            v[0]  <= in_valid;
            id[0] <= in_id;
            for (int i = 1; i < LAT; i++) begin
                v[i]  <= v[i-1];
                id[i] <= id[i-1];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_id    = id[LAT-1];
endmodule

// File: rtl/dsp_share_arbiter.sv
// dsp_share_arbiter: round-robin/lockable sharing of one DSP48A1 slice between two requesters.
// Define DSP_ARB_STATS_EN to add saturating accept and forced-release counters.
module dsp_share_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int LAT      = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_valid,
    input  logic            r1_valid,
    output logic            r0_ready,
    output logic            r1_ready,
    input  logic            r0_lock,
    input  logic            r1_lock,
    input  logic [A_W-1:0]  r0_a,
    input  logic [A_W-1:0]  r1_a,
    input  logic [B_W-1:0]  r0_b,
    input  logic [B_W-1:0]  r1_b,
    input  logic [C_W-1:0]  r0_c,
    input  logic [C_W-1:0]  r1_c,
    input  logic [OP_W-1:0] r0_opmode,
    input  logic [OP_W-1:0] r1_opmode,
    output logic [A_W-1:0]  dsp_a,
    output logic [B_W-1:0]  dsp_b,
    output logic [C_W-1:0]  dsp_c,
    output logic [OP_W-1:0] dsp_opmode,
    output logic            dsp_ce,
    input  logic [P_W-1:0]  dsp_p,
    output logic [P_W-1:0]  rsp_p,
    output logic            r0_rsp_valid,
    output logic            r1_rsp_valid
`ifdef DSP_ARB_STATS_EN
    ,
    output logic [15:0]     stat_g0,
    output logic [15:0]     stat_g1,
    output logic [7:0]      stat_force
`endif
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t        state;
    logic          last_served;
    logic [CW-1:0] lock_cnt;
    logic          id_q;
    logic          acc;
    logic          win;
    logic          lk;
    logic          hold;
    logic          forced;
    logic          pv;
    logic          pid;

    always_comb begin
        r0_ready = !rst && (state == OWN0 ? r0_valid :
                            state == OWN1 ? 1'b0 :
                            r0_valid && (!r1_valid || last_served));
        r1_ready = !rst && (state == OWN1 ? r1_valid :
                            state == OWN0 ? 1'b0 :
                            r1_valid && (!r0_valid || !last_served));
        acc    = (r0_valid && r0_ready) || (r1_valid && r1_ready);
        win    = r1_valid && r1_ready;
        lk     = win ? r1_lock : r0_lock;
        hold   = lk && (int'(lock_cnt) + 1 < LOCK_MAX);
        forced = lk && !hold;
    end

    // last_served always records the winner, so a forced release hands the next tie to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lock_cnt    <= '0;
            id_q        <= 1'b0;
            dsp_a       <= '0;
            dsp_b       <= '0;
            dsp_c       <= '0;
            dsp_opmode  <= '0;
            dsp_ce      <= 1'b0;
        end else begin
            dsp_ce <= acc;
            if (acc) begin
                dsp_a       <= win ? r1_a : r0_a;
                dsp_b       <= win ? r1_b : r0_b;
                dsp_c       <= win ? r1_c : r0_c;
                dsp_opmode  <= win ? r1_opmode : r0_opmode;
                id_q        <= win;
                last_served <= win;
                state       <= hold ? (win ? OWN1 : OWN0) : IDLE;
                lock_cnt    <= hold ? lock_cnt + 1'b1 : '0;
            end
        end
    end

    dsp_tag_pipe #(.LAT(LAT)) u_tag (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (dsp_ce),
        .in_id     (id_q),
        .out_valid (pv),
        .out_id    (pid)
    );

    assign rsp_p        = dsp_p;
    assign r0_rsp_valid = pv && !pid;
    assign r1_rsp_valid = pv && pid;

`ifdef DSP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_g0    <= '0;
            stat_g1    <= '0;
            stat_force <= '0;
        end else begin
            if (acc && !win && stat_g0 != 16'hFFFF) stat_g0 <= stat_g0 + 1'b1;
            if (acc && win && stat_g1 != 16'hFFFF) stat_g1 <= stat_g1 + 1'b1;
            if (acc && forced && stat_force != 8'hFF) stat_force <= stat_force + 1'b1;
        end
    end
`endif
endmodule

// File: doc/dsp_share_arbiter.md
Name: dsp_share_arbiter

Overview:
Shares one DSP48A1 multiply-accumulate slice between two requesters. Operands are issued through a round-robin arbiter with a lock option, so one requester can hold the slice for back-to-back accumulation using P feedback. A tag pipeline matched to the slice latency routes each result back to the requester that issued it. It sits between two datapath clients and the DSP48A1 top-level operand/OPMODE/CE ports.

Parameters:
LAT, 4, cycles from dsp_ce=1 to the matching dsp_p being valid; legal range 1..16
LOCK_MAX, 8, maximum consecutive ops accepted under lock before a forced release; legal range 1..255

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-high reset
r0_valid / r1_valid  in  1  requester has an op pending
r0_ready / r1_ready  out  1  op accepted this cycle when valid&ready
r0_lock / r1_lock  in  1  keep the grant after this op
r0_a / r1_a  in  18  A operand
r0_b / r1_b  in  18  B operand
r0_c / r1_c  in  48  C operand
r0_opmode / r1_opmode  in  8  OPMODE for this op
dsp_a  out  18; dsp_b  out  18; dsp_c  out  48; dsp_opmode  out  8  registered operands to the slice
dsp_ce  out  1  one-cycle issue strobe
dsp_p  in  48  slice P output
rsp_p  out  48  result, combinational pass-through of dsp_p
r0_rsp_valid / r1_rsp_valid  out  1  rsp_p belongs to this requester this cycle

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, last_served=1 (r0 wins the first tie), lock_cnt=0, tag pipe cleared.
  - dsp_a/b/c/opmode=0, dsp_ce=0, rsp_valid=0, ready=0.
  - In-flight results are dropped with no response.
- Ready is combinational from state and valid:
  - IDLE: only r0 valid -> r0_ready; only r1 valid -> r1_ready; both valid -> the requester != last_served.
  - OWN0: r0_ready=r0_valid, r1_ready=0. OWN1 mirrors this.
  - At most one ready is high per cycle.
- Accept (valid&ready) on edge N:
  - dsp_* <= winner's operands and dsp_ce=1 for cycle N+1.
  - last_served <= winner.
  - With no accept: dsp_ce=0 and operands hold their value.
- State transitions on accept by requester X:
  - lock=1 and lock_cnt+1 < LOCK_MAX -> OWNX, lock_cnt += 1.
  - lock=0, or lock_cnt+1 == LOCK_MAX -> IDLE, lock_cnt=0. On a forced release the other requester wins the next tie.
  - In OWNX with no accept (owner deasserts valid), state is held; the lock survives idle cycles.
- Tag pipe:
  - LAT-deep shift of {valid,id}; stage 0 is loaded on each accept.
  - Output stage drives rX_rsp_valid exactly LAT+1 cycles after the accept edge (1 issue register plus LAT).
  - Responses come back in issue order and no response is ever dropped outside reset.
- Throughput: one op per cycle sustained; uncontended back-to-back accepts from one requester are allowed.
- Width rules: lock_cnt width $clog2(LOCK_MAX+1). No arithmetic on data; operands pass unmodified.

Optional Feature:
DSP_ARB_STATS_EN
- Defined:
  - Adds outputs stat_g0 and stat_g1 (16 bits each), saturating counts of accepts per requester.
  - Adds stat_force (8 bits), a saturating count of forced lock releases.
  - All three clear on RST.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package dsp_arb_pkg holds:
  - state enum {IDLE, OWN0, OWN1};
  - width constants A_W=18, B_W=18, C_W=48, OP_W=8, P_W=48.
- One sub-module, dsp_tag_pipe (parameter LAT): the {valid,id} shift register with async clear.
- The arbiter FSM and operand registers stay in the top module.

Test Plan:
- Single op: r0 valid, a=3, b=5, opmode=8'h01 at cycle 1 -> dsp_ce=1 at cycle 2 with dsp_a=3, dsp_b=5; r0_rsp_valid=1 at cycle 2+LAT; r1_rsp_valid stays 0.
- Contention: r0 and r1 valid continuously, no lock -> accepts alternate r0,r1,r0,r1; rsp_valid alternates in the same order LAT+1 cycles later.
- Lock: r1 valid with lock=1 for 3 ops, then lock=0, while r0 stays valid -> r1 gets 4 consecutive accepts, then r0 is granted.
- Forced release with LOCK_MAX=8: r0 locked continuously and r1 valid -> r0 gets 8 accepts, r1 accepts next, stat_force=1 (with DSP_ARB_STATS_EN).
- Lock hold across idle: r0 locked, drops valid for 5 cycles while r1 valid -> r1_ready stays 0 throughout.
- Reset mid-flight: RST pulse 2 cycles after an accept -> dsp_ce=0, all dsp_* and rsp_valid=0 immediately, no stale rsp_valid after release, r0 wins the next tie.
